// File: rtl/restart_scheduler.sv
// Luby-sequence restart scheduler: arms on enable, requests a solver restart on pending, advances on ack.
// Build option: define RESTART_LUBY_EN for the Luby multiplier; otherwise the threshold is a flat BASE_INTERVAL.
module restart_scheduler #(
  parameter logic [15:0] BASE_INTERVAL = 16'd100,
  parameter int          LUBY_MAX_EXP  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        restart_pending,
  input  logic        restart_ack,
  output logic [15:0] restart_threshold,
  output logic        restart_req,
  output logic        clear_restart_counter,
  output logic        inc_restart,
  output logic [15:0] luby_value
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    REQ     = 2'd2,
    ADVANCE = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [15:0] v_nx;
  logic [31:0] product;
  logic [15:0] threshold_nx;
  logic        req_nx;
  logic        advance_nx;

  // The cap 2^LUBY_MAX_EXP must fit in the 16-bit multiplier.
  if (LUBY_MAX_EXP < 0 || LUBY_MAX_EXP > 15) begin : g_bad_cap
    $error("restart_scheduler: LUBY_MAX_EXP must be within 0..15");
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (!enable) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE:    state_nx = ARMED;
        ARMED:   if (restart_pending) state_nx = REQ;
        REQ:     if (restart_ack) state_nx = ADVANCE;
        ADVANCE: state_nx = ARMED;
        default: state_nx = IDLE;
      endcase
    end
  end

`ifdef RESTART_LUBY_EN
  localparam logic [15:0] V_CAP = 16'd1 << LUBY_MAX_EXP;

  logic [15:0] u;
  logic [15:0] v;
  logic [15:0] u_nx;
  logic [15:0] u_low;

  assign u_low = u & (~u + 16'd1);

  // (u,v) only step when ADVANCE completes; an enable drop during ADVANCE keeps them.
  always_comb begin
    u_nx = u;
    v_nx = v;
    if (state == ADVANCE && state_nx == ARMED) begin
      if (u_low == v || v == V_CAP) begin
        u_nx = (u == 16'hFFFF) ? 16'd1 : u + 16'd1;
        v_nx = 16'd1;
      end else begin
        v_nx = v << 1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u <= 16'd1;
      v <= 16'd1;
    end else begin
      u <= u_nx;
      v <= v_nx;
    end
  end

  assign luby_value = v;
`else
  assign v_nx       = 16'd1;
  assign luby_value = 16'd1;
`endif

  assign product = 32'(BASE_INTERVAL) * 32'(v_nx);

  always_comb begin
    threshold_nx = 16'd0;
    if (state_nx != IDLE) begin
      threshold_nx = (product[31:16] != 16'd0) ? 16'hFFFF : product[15:0];
    end
    req_nx     = (state_nx == REQ);
    advance_nx = (state_nx == ADVANCE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      restart_threshold     <= 16'd0;
      restart_req           <= 1'b0;
      clear_restart_counter <= 1'b0;
      inc_restart           <= 1'b0;
    end else begin
      restart_threshold     <= threshold_nx;
      restart_req           <= req_nx;
      clear_restart_counter <= advance_nx;
      inc_restart           <= advance_nx;
    end
  end

endmodule

// File: doc/restart_scheduler.md
RESTART_SCHEDULER -- requirements
Module: restart_scheduler

Interface
REQ-001 Parameter BASE_INTERVAL, default 100, sets conflicts per Luby unit (16-bit).
REQ-002 Parameter LUBY_MAX_EXP, default 10, caps the Luby multiplier v at 2^LUBY_MAX_EXP.
REQ-003 clk  in  1  clock; all state samples on the rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 enable  in  1  restart policy active; low means restarts are suppressed.
REQ-006 restart_pending  in  1  conflict counter has reached the current threshold.
REQ-007 restart_ack  in  1  single-cycle pulse: solver finished backtrack to level 0.
REQ-008 restart_threshold  out  16  threshold presented to the statistics counter block.
REQ-009 restart_req  out  1  level request to the solver core to perform a restart.
REQ-010 clear_restart_counter  out  1  single-cycle pulse clearing the conflict-since-restart counter.
REQ-011 inc_restart  out  1  single-cycle pulse incrementing the total restart count.
REQ-012 luby_value  out  16  current multiplier v.

Function
REQ-013 FSM states are IDLE, ARMED, REQ and ADVANCE; all outputs are registered.
REQ-014 IDLE: go to ARMED when enable=1; restart_threshold=0 while in IDLE.
REQ-015 ARMED: go to REQ on the next edge when restart_pending=1; restart_req=1 throughout REQ.
REQ-016 REQ: hold restart_req=1 until restart_ack=1, then go to ADVANCE; there is no timeout.
REQ-017 ADVANCE lasts exactly one cycle: clear_restart_counter=1, inc_restart=1, restart_req=0, and (u,v) advance; then go to ARMED.
REQ-018 Luby state is u,v, both 16-bit; initial values u=1, v=1.
REQ-019 Advance rule: if lowbit(u)==v or v==2^LUBY_MAX_EXP, then u<=u+1 and v<=1; otherwise v<=2v.
REQ-020 u wrap: if u==16'hFFFF on the increment path, then u<=1 and v<=1.
REQ-021 restart_threshold = BASE_INTERVAL*v, saturating at 16'hFFFF; it is registered and updates the cycle after ADVANCE.
REQ-022 Outside IDLE, restart_threshold never reads 0.
REQ-023 enable=0 in any state forces IDLE on the next edge: restart_req drops, no ADVANCE pulses are issued, and u,v are retained.
REQ-024 Priority: enable=0 overrides restart_pending and restart_ack in the same cycle.
REQ-025 restart_ack is ignored in IDLE, ARMED and ADVANCE.
REQ-026 restart_pending is ignored in REQ and ADVANCE, so no double request is issued.

Reset
REQ-027 rst_n=0 asynchronously sets state=IDLE, u=1, v=1, restart_threshold=0, restart_req=0, clear_restart_counter=0, inc_restart=0, luby_value=1.
REQ-028 Reset asserted mid-handshake aborts with no pulses, and restart_req falls immediately.

Configuration
REQ-029 Macro RESTART_LUBY_EN defined: Luby schedule per REQ-018 to REQ-021.
REQ-030 Macro RESTART_LUBY_EN undefined: u,v are not implemented, v is constant 1, luby_value=1, restart_threshold=BASE_INTERVAL outside IDLE, and the FSM and handshake are unchanged.

Verification
REQ-031 Build with RESTART_LUBY_EN, BASE_INTERVAL=100, eight pending/ack rounds -> thresholds 100,100,200,100,100,200,400,100.
REQ-032 LUBY_MAX_EXP=1, six rounds -> luby_value is 1,1,2,1,1,2 and never exceeds 2.
REQ-033 BASE_INTERVAL=40000, reach v=2 -> restart_threshold=16'hFFFF (saturated).
REQ-034 restart_pending=1, then drop enable while in REQ before ack -> restart_req=0 on the next cycle, no inc_restart pulse, and luby_value is unchanged after re-enable.
REQ-035 Assert restart_ack in ARMED, and hold restart_pending high through ADVANCE -> no spurious pulse, and exactly one inc_restart per ack.
REQ-036 Build without RESTART_LUBY_EN, BASE_INTERVAL=100, five rounds -> threshold stays at 100 and five inc_restart pulses are issued.
